// File: rtl/udm_uart_rx_fifo.sv
// udm_uart_rx_fifo: UART receiver for the UDM debug path.
// It has a runtime baud divider, optional even/odd parity, an internal
// receive FIFO drained through valid/ready, and sticky error flags.
// Optional feature macro: UDM_UART_RX_BREAK_DET_EN. When it is defined,
// an all-zero frame including the stop bit is reported as a break pulse
// instead of a framing error.
module udm_uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 32
) (
  input  logic                            clk_i,
  input  logic                            arst_ni,
  input  logic                            rx_i,
  input  logic [DIV_W-1:0]                div_i,
  input  logic [1:0]                      parity_mode_i,
  output logic [DATA_W-1:0]               data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o,
  output logic                            busy_o,
  output logic                            frame_err_o,
  output logic                            parity_err_o,
  output logic                            overrun_err_o,
  input  logic                            clr_err_i,
  output logic                            break_o
);

  localparam int LVL_W = $clog2(FIFO_DEPTH+1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W-1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic                sync_q;
  logic                rxs;
  logic                rxs_prev;

  state_t              state;
  state_t              state_n;
  logic [DIV_W-1:0]    cnt;
  logic [DIV_W-1:0]    cnt_n;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    div_n;
  logic [DIV_W-1:0]    div_eff;
  logic [1:0]          pmode_q;
  logic [1:0]          pmode_n;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_n;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   shreg_n;
  logic                par_err_q;
  logic                par_err_n;
  logic                par_en;
  logic                par_odd;

  logic                push;
  logic                set_frame;
  logic                set_parity;
  logic                set_overrun;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    count;
  logic                full;
  logic                pop;
  logic                push_ok;

`ifdef UDM_UART_RX_BREAK_DET_EN
  logic                brk_wait_q;
  logic                brk_wait_n;
  logic                par_bit_q;
  logic                par_bit_n;
  logic                set_break;
  logic                break_q;
`endif

  // Divider values below 2 would make the half-bit and per-bit counts degenerate.
  assign div_eff = (div_i < DIV_W'(2)) ? DIV_W'(2) : div_i;

  // Mode 11 behaves like "no parity".
  assign par_en  = (pmode_q == 2'b01) || (pmode_q == 2'b10);
  assign par_odd = (pmode_q == 2'b10);

  // Two-flop synchroniser for the asynchronous line, plus the previous value for edge detect.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      sync_q   <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync_q   <= rx_i;
      rxs      <= sync_q;
      rxs_prev <= rxs;
    end
  end

  // Receiver state and frame datapath registers.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state     <= S_IDLE;
      cnt       <= '0;
      div_q     <= '0;
      pmode_q   <= 2'b00;
      idx       <= '0;
      shreg     <= '0;
      par_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      div_q     <= div_n;
      pmode_q   <= pmode_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      par_err_q <= par_err_n;
    end
  end

`ifdef UDM_UART_RX_BREAK_DET_EN
  // Break bookkeeping: the sampled parity bit, the wait-for-idle flag and the one-cycle pulse.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      brk_wait_q <= 1'b0;
      par_bit_q  <= 1'b0;
      break_q    <= 1'b0;
    end else begin
      brk_wait_q <= brk_wait_n;
      par_bit_q  <= par_bit_n;
      break_q    <= set_break;
    end
  end

  assign break_o = break_q;
`else
  assign break_o = 1'b0;
`endif

  // Next-state logic: bit timing, sampling, parity check and the stop-bit verdict.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    div_n      = div_q;
    pmode_n    = pmode_q;
    idx_n      = idx;
    shreg_n    = shreg;
    par_err_n  = par_err_q;
    push       = 1'b0;
    set_frame  = 1'b0;
    set_parity = 1'b0;
`ifdef UDM_UART_RX_BREAK_DET_EN
    brk_wait_n = brk_wait_q;
    par_bit_n  = par_bit_q;
    set_break  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (rxs_prev && !rxs) begin
          state_n = S_START;
          cnt_n   = div_eff >> 1;
          div_n   = div_eff;
          pmode_n = parity_mode_i;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          if (rxs) begin
            state_n = S_IDLE;
          end else begin
            state_n   = S_DATA;
            cnt_n     = div_q - DIV_W'(1);
            idx_n     = '0;
            par_err_n = 1'b0;
          end
        end else begin
          cnt_n = cnt - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          shreg_n = {rxs, shreg[DATA_W-1:1]};
          cnt_n   = div_q - DIV_W'(1);
          if (idx == LAST_IDX) begin
            state_n = par_en ? S_PARITY : S_STOP;
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt - DIV_W'(1);
        end
      end
      S_PARITY: begin
        if (cnt == '0) begin
          par_err_n = ((^shreg) ^ rxs) != par_odd;
`ifdef UDM_UART_RX_BREAK_DET_EN
          par_bit_n = rxs;
`endif
          cnt_n     = div_q - DIV_W'(1);
          state_n   = S_STOP;
        end else begin
          cnt_n = cnt - DIV_W'(1);
        end
      end
      S_STOP: begin
`ifdef UDM_UART_RX_BREAK_DET_EN
        if (brk_wait_q) begin
          if (rxs) begin
            state_n    = S_IDLE;
            brk_wait_n = 1'b0;
          end
        end else
`endif
        if (cnt == '0) begin
          state_n = S_IDLE;
          if (!rxs) begin
`ifdef UDM_UART_RX_BREAK_DET_EN
            if ((shreg == '0) && (!par_en || !par_bit_q)) begin
              set_break  = 1'b1;
              brk_wait_n = 1'b1;
              state_n    = S_STOP;
            end else begin
              set_frame = 1'b1;
            end
`else
            set_frame = 1'b1;
`endif
          end else if (par_err_q) begin
            set_parity = 1'b1;
          end else begin
            push = 1'b1;
          end
        end else begin
          cnt_n = cnt - DIV_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy_o = (state != S_IDLE);

  // A full FIFO still accepts a word when the head is popped in the same cycle.
  assign full        = (count == FULL_LVL);
  assign pop         = valid_o && ready_i;
  assign push_ok     = push && (!full || pop);
  assign set_overrun = push && full && !pop;

  assign valid_o = (count != '0);
  assign level_o = count;
  assign data_o  = mem[rd_ptr];

  // Receive FIFO storage, wrapping pointers and exact occupancy count.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      frame_err_o   <= 1'b0;
      parity_err_o  <= 1'b0;
      overrun_err_o <= 1'b0;
    end else begin
      if (set_frame) begin
        frame_err_o <= 1'b1;
      end else if (clr_err_i) begin
        frame_err_o <= 1'b0;
      end
      if (set_parity) begin
        parity_err_o <= 1'b1;
      end else if (clr_err_i) begin
        parity_err_o <= 1'b0;
      end
      if (set_overrun) begin
        overrun_err_o <= 1'b1;
      end else if (clr_err_i) begin
        overrun_err_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udm_uart_rx_fifo.sv
// tb_udm_uart_rx_fifo: scoreboard bench for udm_uart_rx_fifo.
// Expected words are queued when a frame is issued; a monitor pops and
// compares them whenever the receiver hands a word over.
// Break expectations follow UDM_UART_RX_BREAK_DET_EN.
module tb_udm_uart_rx_fifo;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 32;

`ifdef UDM_UART_RX_BREAK_DET_EN
  localparam bit BREAK_EN = 1'b1;
`else
  localparam bit BREAK_EN = 1'b0;
`endif

  logic              clk_i         = 1'b0;
  logic              arst_ni       = 1'b0;
  logic              rx_i          = 1'b1;
  logic [DIV_W-1:0]  div_i         = 32'd16;
  logic [1:0]        parity_mode_i = 2'b00;
  logic [DATA_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i       = 1'b0;
  logic [2:0]        level_o;
  logic              busy_o;
  logic              frame_err_o;
  logic              parity_err_o;
  logic              overrun_err_o;
  logic              clr_err_i     = 1'b0;
  logic              break_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] expQ[$];
  int         modelLevel = 0;
  bit         expFrame   = 1'b0;
  bit         expParity  = 1'b0;
  bit         expOverrun = 1'b0;
  int         breakCount = 0;
  bit         readyRand  = 1'b0;
  bit         readyFixed = 1'b1;

  udm_uart_rx_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_W     (DIV_W)
  ) dut (
    .clk_i        (clk_i),
    .arst_ni      (arst_ni),
    .rx_i         (rx_i),
    .div_i        (div_i),
    .parity_mode_i(parity_mode_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .level_o      (level_o),
    .busy_o       (busy_o),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .overrun_err_o(overrun_err_o),
    .clr_err_i    (clr_err_i),
    .break_o      (break_o)
  );

  // 10 ns system clock.
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Consumer handshake, either fixed or randomly stalling.
  always @(posedge clk_i) begin
    #1;
    ready_i = readyRand ? 1'($urandom_range(0, 1)) : readyFixed;
  end

  // Monitor: compares every handed-over word against the scoreboard and counts break pulses.
  always @(negedge clk_i) begin
    if (arst_ni) begin
      if (break_o) breakCount++;
      if (valid_o && ready_i) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got %0h, expected no word", data_o);
        end else begin
          checkOutput("fifo_data", 32'(data_o), 32'(expQ.pop_front()));
          modelLevel--;
        end
      end
    end
  end

  // Hold the line at b for n clock cycles; always leaves us just after a rising edge.
  task automatic driveBit(input logic b, input int n);
    rx_i = b;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Send one frame and record what the receiver must do with it.
  task automatic applyStimulus(input logic [7:0] data, input int div, input logic [1:0] pmode,
                               input bit badPar, input bit badStop);
    bit parEn;
    bit parBit;
    parEn  = (pmode == 2'b01) || (pmode == 2'b10);
    parBit = (pmode == 2'b10) ? ~(^data) : (^data);
    if (badPar) parBit = ~parBit;
    if (badStop) expFrame = 1'b1;
    else if (parEn && badPar) expParity = 1'b1;
    else if (modelLevel == FIFO_DEPTH) expOverrun = 1'b1;
    else begin
      expQ.push_back(data);
      modelLevel++;
    end
    div_i         = DIV_W'(div);
    parity_mode_i = pmode;
    driveBit(1'b0, div);
    // Settings are captured at the start edge; scrambling them now must not matter.
    div_i         = DIV_W'($urandom_range(2, 40));
    parity_mode_i = 2'($urandom_range(0, 3));
    for (int i = 0; i < 8; i++) driveBit(data[i], div);
    if (parEn) driveBit(parBit, div);
    driveBit(!badStop, div);
    driveBit(1'b1, 6);
  endtask

  task automatic checkFlags(input string name);
    @(negedge clk_i);
    checkOutput({name, "_frame"},   32'(frame_err_o),   32'(expFrame));
    checkOutput({name, "_parity"},  32'(parity_err_o),  32'(expParity));
    checkOutput({name, "_overrun"}, 32'(overrun_err_o), 32'(expOverrun));
    checkOutput({name, "_busy"},    32'(busy_o),        32'd0);
    if (!readyRand) checkOutput({name, "_level"}, 32'(level_o), 32'(modelLevel));
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_data"},    32'(data_o),        32'd0);
    checkOutput({name, "_valid"},   32'(valid_o),       32'd0);
    checkOutput({name, "_level"},   32'(level_o),       32'd0);
    checkOutput({name, "_busy"},    32'(busy_o),        32'd0);
    checkOutput({name, "_frame"},   32'(frame_err_o),   32'd0);
    checkOutput({name, "_parity"},  32'(parity_err_o),  32'd0);
    checkOutput({name, "_overrun"}, 32'(overrun_err_o), 32'd0);
    checkOutput({name, "_break"},   32'(break_o),       32'd0);
  endtask

  task automatic pulseClear();
    clr_err_i = 1'b1;
    @(posedge clk_i);
    #1;
    clr_err_i  = 1'b0;
    expFrame   = 1'b0;
    expParity  = 1'b0;
    expOverrun = 1'b0;
  endtask

  task automatic drainFifo(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 1000) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    checkOutput(name, 32'(expQ.size()), 32'd0);
  endtask

  // Main sequence: directed scenarios first, then randomized frames.
  initial begin
    int b0;
    logic [7:0] rdata;
    bit rbadStop;

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkAllZero("reset");
    @(posedge clk_i);
    #1;
    arst_ni = 1'b1;
    driveBit(1'b1, 4);

    $display("[TB] basic receive");
    applyStimulus(8'h55, 16, 2'b00, 1'b0, 1'b0);
    checkFlags("basic_55");
    applyStimulus(8'hA3, 16, 2'b00, 1'b0, 1'b0);
    checkFlags("basic_A3");

    $display("[TB] parity");
    applyStimulus(8'h5A, 16, 2'b01, 1'b0, 1'b0);
    checkFlags("even_ok");
    applyStimulus(8'h5A, 16, 2'b10, 1'b1, 1'b0);
    checkFlags("odd_bad");
    pulseClear();
    checkFlags("par_clear");

    $display("[TB] framing");
    applyStimulus(8'h81, 16, 2'b00, 1'b0, 1'b1);
    checkFlags("frame_81");
    applyStimulus(8'h42, 16, 2'b00, 1'b0, 1'b0);
    checkFlags("after_frame_42");
    pulseClear();
    drainFifo("drain_basic");

    $display("[TB] overrun");
    readyFixed = 1'b0;
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 16, 2'b00, 1'b0, 1'b0);
    checkFlags("overrun");
    checkOutput("full_level", 32'(level_o), 32'd4);
    readyFixed = 1'b1;
    drainFifo("drain_overrun");
    driveBit(1'b1, 4);
    checkOutput("drained_level", 32'(level_o), 32'd0);
    pulseClear();

    $display("[TB] glitch");
    div_i         = 32'd16;
    parity_mode_i = 2'b00;
    driveBit(1'b0, 3);
    driveBit(1'b1, 30);
    checkFlags("glitch");

    $display("[TB] reset mid-frame");
    driveBit(1'b0, 16);
    driveBit(1'b1, 16);
    driveBit(1'b0, 16);
    driveBit(1'b1, 8);
    checkOutput("mid_frame_busy", 32'(busy_o), 32'd1);
    arst_ni = 1'b0;
    #1;
    checkAllZero("async_reset");
    rx_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    arst_ni    = 1'b1;
    modelLevel = 0;
    driveBit(1'b1, 4);
    applyStimulus(8'hC3, 16, 2'b00, 1'b0, 1'b0);
    checkFlags("after_reset_C3");
    drainFifo("drain_reset");

    $display("[TB] break");
    b0            = breakCount;
    div_i         = 32'd16;
    parity_mode_i = 2'b00;
    driveBit(1'b0, 12 * 16);
    driveBit(1'b1, 40);
    checkOutput("break_pulses", 32'(breakCount - b0), BREAK_EN ? 32'd1 : 32'd0);
    if (!BREAK_EN) expFrame = 1'b1;
    checkFlags("break");
    pulseClear();

    $display("[TB] random frames");
    readyRand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rdata    = 8'($urandom_range(0, 255));
      rbadStop = ($urandom_range(0, 9) == 0);
      if (rbadStop && rdata == 8'h00) rdata = 8'h01;
      applyStimulus(rdata, $urandom_range(8, 24), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 6) == 0), rbadStop);
      checkFlags("random");
      if ((n % 8) == 7) pulseClear();
    end
    readyRand  = 1'b0;
    readyFixed = 1'b1;
    drainFifo("drain_random");
    driveBit(1'b1, 4);
    checkOutput("final_level", 32'(level_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udm_uart_rx_fifo.md
Name: udm_uart_rx_fifo

Overview:
Parametrised UART receiver for the debug path. Supports a runtime baud divider, configurable data width, and selectable parity. Received words go into an internal FIFO drained through a valid/ready interface. Frame, parity and overrun errors are latched as sticky flags. It replaces the fixed 8N1 receiver in front of the UDM command decoder, so the debug link can run at any of the 2400–115200 baud divider settings.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9; sent LSB first.
FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2.
DIV_W, 32, width of the runtime baud divider input.

Ports:
clk_i  in  1  system clock
arst_ni  in  1  asynchronous active-low reset
rx_i  in  1  serial line, idle high, asynchronous to clk_i
div_i  in  DIV_W  clock cycles per bit; values below 2 are treated as 2
parity_mode_i  in  2  00 none, 01 even, 10 odd, 11 treated as none
data_o  out  DATA_W  FIFO head word
valid_o  out  1  FIFO not empty
ready_i  in  1  consumer accepts the head word
level_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
busy_o  out  1  receiver FSM is not in IDLE
frame_err_o  out  1  sticky: stop bit sampled low
parity_err_o  out  1  sticky: parity mismatch
overrun_err_o  out  1  sticky: good word arrived while FIFO full with no pop
clr_err_i  in  1  one-cycle pulse clears all sticky error flags
break_o  out  1  break pulse (see Optional Feature; constant 0 when disabled)

Behaviour:
- Reset (arst_ni low, asynchronous):
  - FSM goes to IDLE; FIFO empties; all outputs 0.
  - Both synchroniser flops reset to 1.
  - Any frame in progress is discarded.
- Input path: rx_i passes through a 2-flop synchroniser (rxs). All timing below is counted from rxs.
- div_i and parity_mode_i are captured when a start bit is detected. Changing them mid-frame has no effect on that frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge of rxs (previous 1, current 0) loads cnt = div/2 and moves to START. A line held low with no edge does not start a frame.
  - START: cnt decrements each cycle. At cnt==0, sample rxs:
    - 1: false start, return to IDLE.
    - 0: load cnt = div-1, clear bit index, go to DATA.
  - DATA: at each cnt==0, shift rxs in at bit[idx] and reload cnt = div-1. After DATA_W bits, go to PARITY if parity is enabled, otherwise STOP.
  - PARITY: sample at cnt==0. Error when XOR(data, sampled bit) != 0 for even parity, or != 1 for odd parity. Go to STOP.
  - STOP: sample at cnt==0, then go to IDLE on the next cycle.
    - Stop bit 0: set frame_err_o and discard the word.
    - Stop bit 1 with parity error: set parity_err_o and discard the word.
    - Otherwise push the word.
- Push timing: the word appears on data_o/valid_o the cycle after the stop-bit sample when the FIFO was empty. First-word latency from the start edge on rxs is approximately div/2 + (DATA_W + parity + 1)*div + 1 cycles.
- FIFO:
  - Pop occurs when valid_o && ready_i.
  - Push and pop in the same cycle with the FIFO full: both take effect and no overrun is flagged.
  - Push while full with no pop: the word is dropped, existing contents are unchanged, overrun_err_o is set.
  - Pop from empty cannot occur (valid_o is 0).
  - Read and write pointers wrap modulo FIFO_DEPTH. level_o is exact at 0 and at FIFO_DEPTH.
- Error flags: sticky until clr_err_i. If clr_err_i and a new error occur in the same cycle, set wins.
- busy_o is high in START, DATA, PARITY and STOP.

Optional Feature:
UDM_UART_RX_BREAK_DET_EN
- Enabled: a frame whose data bits, parity bit (if any) and stop bit are all 0 is a break.
  - break_o pulses for one cycle at the stop sample.
  - No push, no frame_err_o.
  - The FSM waits in STOP until rxs returns to 1, then goes to IDLE.
- Disabled: break_o is tied 0. Such a frame is handled as a framing error (frame_err_o set, word discarded).

Test Plan:
- Basic receive: div=16, parity none, send 0x55 then 0xA3 (8N1) -> data_o 0x55 then 0xA3 in order; no errors; busy_o low after each stop bit.
- Parity: even mode, send 0x5A with correct parity -> pushed. Odd mode, send 0x5A with even-parity bit -> not pushed, parity_err_o=1. clr_err_i pulse -> flag returns to 0.
- Framing: send 0x81 with stop bit 0 -> frame_err_o=1, level_o stays 0. A following good 0x42 is received correctly.
- FIFO full/overrun: ready_i=0, send 5 words 0x01..0x05 with FIFO_DEPTH=4 -> level_o=4, overrun_err_o=1. Then ready_i=1 -> pops 0x01..0x04 only.
- Glitch and reset: 3-cycle low pulse on rx_i -> false start, nothing pushed. Assert arst_ni mid-DATA -> all outputs 0; the next full frame 0xC3 is received correctly.
- Break (macro defined): hold rx low for 12 bit times with div=16 -> one break_o pulse, no push, no frame_err_o. Without the macro the same stimulus -> frame_err_o=1.
